fifo_uart_tx: RTL

Serial transmitter that drains the 8-bit byte FIFO from its dequeue side and shifts each byte out as an asynchronous UART frame on a single line. It sits between the FIFO's `data_out`/`empty_out`/`dequeue_in` pins and the board's debug/link TX pin, and lets any producer log bytes by enqueueing them.

---
 rtl/fifo_uart_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a byte FIFO (pop, load, start, 8 data LSB-first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       enable_in,
  input  logic       fifo_empty_in,
  input  logic [7:0] fifo_data_in,
  output logic       fifo_dequeue_out,
  output logic       tx_out,
  output logic       busy_out
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          deq_q, deq_d;
  logic          busy_q, busy_d;
  logic          bit_done;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    bit_done = (cnt_q == CNT_MAX);

    case (state_q)
      S_IDLE: begin
        if (enable_in && !fifo_empty_in) state_d = S_POP;
      end
      S_POP: state_d = S_LOAD;
      S_LOAD: begin
        shreg_d = fifo_data_in;
`ifdef UART_TX_PARITY_EN
        par_d   = ^fifo_data_in;
`endif
        state_d = S_START;
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
        else          cnt_d   = cnt_q + 1'b1;
      end
`endif
      S_STOP: begin
        if (bit_done) state_d = S_IDLE;
        else          cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state itself.
  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    deq_d  = (state_d == S_POP);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      deq_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      deq_q   <= deq_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_out           = tx_q;
  assign fifo_dequeue_out = deq_q;
  assign busy_out         = busy_q;

endmodule
